// File: rtl/mvu_lut_stream.sv
// rtl/mvu_lut_stream.sv - streaming LUT matrix-vector unit with valid/ready handshakes
// Optional accumulator saturation: define MVU_LUT_STREAM_SAT_EN (default build wraps).
module mvu_lut_stream #(
    parameter int PE                 = 4,
    parameter int SIMD               = 8,
    parameter int ACTIVATION_WIDTH   = 4,
    parameter int WEIGHT_WIDTH       = 4,
    parameter int ACCU_WIDTH         = 16,
    parameter int SIGNED_ACTIVATIONS = 0,
    parameter int SF                 = 16,
    parameter int M_REG              = 1,
    parameter int T_REG              = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]       s_w,
    input  logic [SIMD*ACTIVATION_WIDTH-1:0]      s_a,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [PE*ACCU_WIDTH-1:0]              m_p
);
    localparam int AW = ACTIVATION_WIDTH;
    localparam int WW = WEIGHT_WIDTH;
    localparam int PW = AW + WW;
    localparam int RW = PW + $clog2(SIMD);
    localparam int SW = ((ACCU_WIDTH > RW) ? ACCU_WIDTH : RW) + 1;
    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

    logic w_en;
    logic r_m_valid;
    logic [PE*ACCU_WIDTH-1:0] r_out;

    // A full, unaccepted output register freezes every stage.
    assign w_en    = !(r_m_valid && !m_ready);
    assign s_ready = w_en;
    assign m_valid = r_m_valid;
    assign m_p     = r_out;

    logic [CW-1:0] r_cnt;
    logic r_in_v, r_in_last;
    logic [PE*SIMD*WW-1:0] r_w;
    logic [SIMD*AW-1:0] r_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_in_v    <= 1'b0;
            r_in_last <= 1'b0;
            r_w       <= '0;
            r_a       <= '0;
        end else if (w_en) begin
            r_in_v <= s_valid;
            if (s_valid) begin
                r_w       <= s_w;
                r_a       <= s_a;
                r_in_last <= (r_cnt == CNT_LAST);
                r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    logic [PE*SIMD*PW-1:0] w_prod;
    logic signed [PW-1:0] w_ax, w_wx;

    always_comb begin
        w_prod = '0;
        w_ax   = '0;
        w_wx   = '0;
        for (int p = 0; p < PE; p++) begin
            for (int s = 0; s < SIMD; s++) begin
                if (SIGNED_ACTIVATIONS != 0)
                    w_ax = PW'($signed(r_a[s*AW +: AW]));
                else
                    w_ax = PW'({1'b0, r_a[s*AW +: AW]});
                w_wx = PW'($signed(r_w[(p*SIMD+s)*WW +: WW]));
                w_prod[(p*SIMD+s)*PW +: PW] = w_ax * w_wx;
            end
        end
    end

    logic [PE*SIMD*PW-1:0] w_m_prod;
    logic w_m_v, w_m_last;

    if (M_REG != 0) begin : g_mreg
        logic [PE*SIMD*PW-1:0] r_prod;
        logic r_v, r_last;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prod <= '0;
                r_v    <= 1'b0;
                r_last <= 1'b0;
            end else if (w_en) begin
                r_prod <= w_prod;
                r_v    <= r_in_v;
                r_last <= r_in_last;
            end
        end
        assign w_m_prod = r_prod;
        assign w_m_v    = r_v;
        assign w_m_last = r_last;
    end else begin : g_mcomb
        assign w_m_prod = w_prod;
        assign w_m_v    = r_in_v;
        assign w_m_last = r_in_last;
    end

    logic [PE*RW-1:0] w_root;
    logic signed [RW-1:0] w_sum;

    always_comb begin
        w_root = '0;
        w_sum  = '0;
        for (int p = 0; p < PE; p++) begin
            w_sum = '0;
            for (int s = 0; s < SIMD; s++)
                w_sum = w_sum + RW'($signed(w_m_prod[(p*SIMD+s)*PW +: PW]));
            w_root[p*RW +: RW] = w_sum;
        end
    end

    logic [PE*RW-1:0] w_t_root;
    logic w_t_v, w_t_last;

    if (T_REG != 0) begin : g_treg
        logic [PE*RW-1:0] r_root;
        logic r_v, r_last;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_root <= '0;
                r_v    <= 1'b0;
                r_last <= 1'b0;
            end else if (w_en) begin
                r_root <= w_root;
                r_v    <= w_m_v;
                r_last <= w_m_last;
            end
        end
        assign w_t_root = r_root;
        assign w_t_v    = r_v;
        assign w_t_last = r_last;
    end else begin : g_tcomb
        assign w_t_root = w_root;
        assign w_t_v    = w_m_v;
        assign w_t_last = w_m_last;
    end

`ifdef MVU_LUT_STREAM_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX =
        $signed({{(SW-ACCU_WIDTH+1){1'b0}}, {(ACCU_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN =
        $signed({{(SW-ACCU_WIDTH+1){1'b1}}, {(ACCU_WIDTH-1){1'b0}}});
`endif

    logic [PE*ACCU_WIDTH-1:0] r_acc, w_next;
    logic signed [SW-1:0] w_wide;

    // The add is done one bit wider than either operand so clamping sees the true sum.
    always_comb begin
        w_next = '0;
        w_wide = '0;
        for (int p = 0; p < PE; p++) begin
            w_wide = SW'($signed(r_acc[p*ACCU_WIDTH +: ACCU_WIDTH]))
                   + SW'($signed(w_t_root[p*RW +: RW]));
`ifdef MVU_LUT_STREAM_SAT_EN
            if (w_wide > SAT_MAX)
                w_next[p*ACCU_WIDTH +: ACCU_WIDTH] = SAT_MAX[ACCU_WIDTH-1:0];
            else if (w_wide < SAT_MIN)
                w_next[p*ACCU_WIDTH +: ACCU_WIDTH] = SAT_MIN[ACCU_WIDTH-1:0];
            else
                w_next[p*ACCU_WIDTH +: ACCU_WIDTH] = w_wide[ACCU_WIDTH-1:0];
`else
            w_next[p*ACCU_WIDTH +: ACCU_WIDTH] = w_wide[ACCU_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_out     <= '0;
            r_m_valid <= 1'b0;
        end else if (w_en) begin
            if (w_t_v) begin
                if (w_t_last) begin
                    r_out <= w_next;
                    r_acc <= '0;
                end else begin
                    r_acc <= w_next;
                end
            end
            r_m_valid <= w_t_v && w_t_last;
        end
    end
endmodule
